// File: rtl/seq_sub10.sv
// Sequential 10-bit subtractor: a - b as a + ~b + 1 over 2/4/4-bit segments with valid/ready handshakes.
// Optional SEQ_SUB10_ABS_EN adds a NEG state so that diff returns |a - b| whenever a < b.
module seq_sub10 #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned SEG0_W = 2,
  parameter int unsigned SEG1_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned SEG2_W  = WIDTH - SEG0_W - SEG1_W;
  localparam int unsigned SEG1_LO = SEG0_W;
  localparam int unsigned SEG2_LO = SEG0_W + SEG1_W;
  localparam int unsigned S0W     = SEG0_W + 1;
  localparam int unsigned S1W     = SEG1_W + 1;
  localparam int unsigned S2W     = SEG2_W + 1;

`ifdef SEQ_SUB10_ABS_EN
  typedef enum logic [2:0] {IDLE, SEG0, SEG1, SEG2, NEG, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, SEG0, SEG1, SEG2, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SEG0_W:0]  sum0_c;
  logic [SEG1_W:0]  sum1_c;
  logic [SEG2_W:0]  sum2_c;
  logic [WIDTH-1:0] final_c;

  // Segment adders; each MSB is that segment's carry-out.
  assign sum0_c = S0W'(a_q[SEG0_W-1:0]) + S0W'(nb_q[SEG0_W-1:0]) + S0W'(carry_q);
  assign sum1_c = S1W'(a_q[SEG2_LO-1:SEG1_LO]) + S1W'(nb_q[SEG2_LO-1:SEG1_LO]) + S1W'(carry_q);
  assign sum2_c = S2W'(a_q[WIDTH-1:SEG2_LO]) + S2W'(nb_q[WIDTH-1:SEG2_LO]) + S2W'(carry_q);
  assign final_c = {sum2_c[SEG2_W-1:0], diff_q[SEG2_LO-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      carry_q     <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      carry_q     <= carry_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    nb_d     = nb_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          state_d = SEG0;
        end
      end
      SEG0: begin
        diff_d[SEG0_W-1:0] = sum0_c[SEG0_W-1:0];
        carry_d            = sum0_c[SEG0_W];
        state_d            = SEG1;
      end
      SEG1: begin
        diff_d[SEG2_LO-1:SEG1_LO] = sum1_c[SEG1_W-1:0];
        carry_d                   = sum1_c[SEG1_W];
        state_d                   = SEG2;
      end
      SEG2: begin
        diff_d[WIDTH-1:SEG2_LO] = sum2_c[SEG2_W-1:0];
        carry_d                 = sum2_c[SEG2_W];
        borrow_d                = ~sum2_c[SEG2_W];
        zero_d                  = (final_c == '0);
        ovf_d                   = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ final_c[WIDTH-1]);
`ifdef SEQ_SUB10_ABS_EN
        state_d                 = sum2_c[SEG2_W] ? DONE : NEG;
`else
        state_d                 = DONE;
`endif
      end
`ifdef SEQ_SUB10_ABS_EN
      NEG: begin
        diff_d  = ~diff_q + WIDTH'(1);
        state_d = DONE;
      end
`endif
      DONE: begin
        // Leave only once the result has actually been presented and taken.
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    in_ready_d  = (state_d == IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_sub10.sv
// Randomized self-checking bench for seq_sub10 against an arithmetic reference model.
// Honours SEQ_SUB10_ABS_EN when the build defines it.
module tb_seq_sub10;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] a;
  logic [9:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] diff;
  logic       borrow;
  logic       zero;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_sub10 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input int av, input int bv,
                       output int e_diff, output int e_borrow, output int e_zero,
                       output int e_ovf, output int e_lat);
    int sa, sb, sr;
    e_diff   = (av - bv + 1024) % 1024;
    e_borrow = (av < bv) ? 1 : 0;
    e_zero   = (e_diff == 0) ? 1 : 0;
    sa       = (av >= 512) ? av - 1024 : av;
    sb       = (bv >= 512) ? bv - 1024 : bv;
    sr       = sa - sb;
    e_ovf    = (sr < -512 || sr > 511) ? 1 : 0;
    e_lat    = 4;
`ifdef SEQ_SUB10_ABS_EN
    if (e_borrow == 1) begin
      e_diff = bv - av;
      e_lat  = 5;
    end
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input int av, input int bv, input int stall);
    int e_diff, e_borrow, e_zero, e_ovf, e_lat, cyc;
    model(av, bv, e_diff, e_borrow, e_zero, e_ovf, e_lat);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid  = 1'b1;
    a         = 10'(av);
    b         = 10'(bv);
    out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_busy", int'(in_ready), 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = 10'($urandom_range(0, 1023));
      b         = 10'($urandom_range(0, 1023));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", cyc, e_lat);
    check("diff", int'(diff), e_diff);
    check("borrow", int'(borrow), e_borrow);
    check("zero", int'(zero), e_zero);
    check("ovf", int'(ovf), e_ovf);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = 10'($urandom_range(0, 1023));
      b        = 10'($urandom_range(0, 1023));
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_diff", int'(diff), e_diff);
      check("stall_borrow", int'(borrow), e_borrow);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    int seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 10'd5;
    b         = 10'd1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_borrow", int'(borrow), 0);
    check("rst_zero", int'(zero), 0);
    check("rst_ovf", int'(ovf), 0);
    rst      = 1'b0;
    in_valid = 1'b0;

    run_op(700, 300, 0);
    run_op(5, 9, 0);
    run_op(513, 513, 1);
    run_op(10'h200, 1, 0);
    run_op(3, 1, 6);
    run_op(0, 1023, 0);
    run_op(1023, 0, 0);
    run_op(10'h1FF, 10'h3FF, 0);

    // Reset while the operation is in SEG1, with a fresh in_valid that must lose to reset.
    in_valid = 1'b1;
    a        = 10'd1000;
    b        = 10'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 10'd77;
    b        = 10'd11;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_borrow", int'(borrow), 0);
    check("midrst_zero", int'(zero), 0);
    check("midrst_ovf", int'(ovf), 0);
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    check("midrst_no_pulse", seen_valid, 0);
    run_op(10, 4, 0);

    for (int i = 0; i < 40; i++) begin
      int av, bv;
      av = int'($urandom_range(0, 1023));
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = int'($urandom_range(av, 1023));
        default: bv = int'($urandom_range(0, 1023));
      endcase
      run_op(av, bv, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
